mips_multicycle_control: RTL and testbench

- Multicycle main control FSM for the MIPS core. Sits directly upstream of the ALU control decoder.
- Decodes the latched instruction opcode and sequences FETCH/DECODE/EXECUTE/MEM/WB.
- Drives the 3-bit ALUOp consumed by the ALU control decoder, plus every datapath enable and mux select.
- Consumes the JR flag returned by the ALU control decoder to finish jump-register instructions.

---
 rtl/mips_multicycle_control.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//
// Main control FSM for the multicycle MIPS core. It sequences each instruction
// through FETCH / DECODE / EXECUTE / MEM / WB, drives every datapath enable
// and mux select, and hands a 3-bit operation class (ALUOp) to the ALU
// control decoder. The JR flag returned by that decoder finishes jump-register
// instructions in R_EXEC.
//
// Optional feature: define MIPS_CTRL_JAL_EN to decode opcode 000011 (JAL) into
// the JAL_LINK state. Without it, 000011 is treated as an illegal opcode.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   Opcode       instruction bits [31:26] from the instruction register
//   JR           jump-register flag from the ALU control decoder
//   ALUOp        operation class to the ALU control decoder
//   PCWrite      unconditional PC write
//   PCWriteCond  conditional (branch) PC write
//   BranchNE     0: branch on Zero, 1: branch on !Zero
//   IorD         memory address select: 0 PC, 1 ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   IRWrite      instruction register load
//   MemtoReg     write-back data: 00 ALUOut, 01 MDR, 10 PC
//   RegDst       destination register: 00 rt, 01 rd, 10 $31
//   RegWrite     register file write
//   ALUSrcA      0 PC, 1 register A
//   ALUSrcB      00 regB, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target, 11 register A
//   IllegalOp    one-cycle pulse in DECODE for an unsupported opcode
//   State        current state, for debug

module mips_multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                JR,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                IllegalOp,
    output logic [STATE_W-1:0]  State
);

    typedef enum logic [STATE_W-1:0] {
        IDLE      = STATE_W'(0),
        FETCH     = STATE_W'(1),
        DECODE    = STATE_W'(2),
        MEM_ADDR  = STATE_W'(3),
        MEM_READ  = STATE_W'(4),
        MEM_WB    = STATE_W'(5),
        MEM_WRITE = STATE_W'(6),
        R_EXEC    = STATE_W'(7),
        R_WB      = STATE_W'(8),
        BRANCH    = STATE_W'(9),
        JUMP      = STATE_W'(10),
        I_EXEC    = STATE_W'(11),
        I_WB      = STATE_W'(12),
        JAL_LINK  = STATE_W'(13)
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LUI  = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
`ifdef MIPS_CTRL_JAL_EN
    localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b000011;
`endif

    // Operation classes understood by the ALU control decoder
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b111;

    state_t state;
    state_t next_state;

    // State register; reset drops straight back to IDLE even mid-instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign State = state;

    // Next-state and output decode. Outputs depend only on the state and the
    // latched opcode (plus JR in R_EXEC), so IDLE during reset forces all 0.
    always_comb begin
        next_state  = IDLE;
        ALUOp       = '0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'b00;
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;

        case (state)
            IDLE: begin
                next_state = FETCH;
            end

            // Read the instruction and advance PC by 4 in the same cycle
            FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUOp      = ALU_ADD;
                PCWrite    = 1'b1;
                next_state = DECODE;
            end

            // Precompute the branch target while the opcode is dispatched
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW:                     next_state = MEM_ADDR;
                    OP_R:                             next_state = R_EXEC;
                    OP_BEQ, OP_BNE:                   next_state = BRANCH;
                    OP_J:                             next_state = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = I_EXEC;
`ifdef MIPS_CTRL_JAL_EN
                    OP_JAL:                           next_state = JAL_LINK;
`endif
                    default: begin
                        IllegalOp  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end

            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = ALU_ADD;
                next_state = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = MEM_WB;
            end

            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                next_state = FETCH;
            end

            MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                next_state = FETCH;
            end

            // JR is decoded from funct by the ALU control; when it is set the
            // instruction completes here by loading PC from register A.
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYPE;
                if (JR) begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b11;
                    next_state = FETCH;
                end else begin
                    next_state = R_WB;
                end
            end

            R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                next_state = FETCH;
            end

            // Opcode bit 0 distinguishes BNE from BEQ
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = Opcode[0];
                next_state  = FETCH;
            end

            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                next_state = FETCH;
            end

            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_LUI:  ALUOp = ALU_LUI;
                    default: ALUOp = ALU_ADD;
                endcase
                next_state = I_WB;
            end

            I_WB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end

`ifdef MIPS_CTRL_JAL_EN
            // Link PC+4 into $31 and jump in a single cycle
            JAL_LINK: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                next_state = FETCH;
            end
`endif

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
//
// Directed bench for mips_multicycle_control. The stimulus process drives
// reset/Opcode/JR each cycle and queues the hand-derived output vector for
// that cycle; the monitor process samples the DUT mid-cycle (and right after
// an asynchronous reset assertion) and compares against the queue head.

module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       JR;
    logic [2:0] ALUOp;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .JR(JR),
        .ALUOp(ALUOp), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .BranchNE(BranchNE), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal_op;
    } out_t;

    typedef struct {
        out_t  v;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Hand-written expected vectors, one per state of the control table
    function automatic out_t e_blank(input logic [3:0] s);
        out_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic out_t e_idle();
        return e_blank(4'd0);
    endfunction

    function automatic out_t e_fetch();
        out_t o = e_blank(4'd1);
        o.mem_read = 1'b1; o.ir_write = 1'b1; o.alu_src_b = 2'b01;
        o.alu_op = 3'b100; o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic out_t e_decode(input logic ill);
        out_t o = e_blank(4'd2);
        o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.illegal_op = ill;
        return o;
    endfunction

    function automatic out_t e_mem_addr();
        out_t o = e_blank(4'd3);
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic out_t e_mem_read();
        out_t o = e_blank(4'd4);
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction

    function automatic out_t e_mem_wb();
        out_t o = e_blank(4'd5);
        o.reg_write = 1'b1; o.mem_to_reg = 2'b01;
        return o;
    endfunction

    function automatic out_t e_mem_write();
        out_t o = e_blank(4'd6);
        o.mem_write = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction

    function automatic out_t e_r_exec(input logic jr);
        out_t o = e_blank(4'd7);
        o.alu_src_a = 1'b1; o.alu_op = 3'b111;
        o.pc_write = jr; o.pc_source = jr ? 2'b11 : 2'b00;
        return o;
    endfunction

    function automatic out_t e_r_wb();
        out_t o = e_blank(4'd8);
        o.reg_write = 1'b1; o.reg_dst = 2'b01;
        return o;
    endfunction

    function automatic out_t e_branch(input logic ne);
        out_t o = e_blank(4'd9);
        o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_write_cond = 1'b1;
        o.pc_source = 2'b01; o.branch_ne = ne;
        return o;
    endfunction

    function automatic out_t e_jump();
        out_t o = e_blank(4'd10);
        o.pc_write = 1'b1; o.pc_source = 2'b10;
        return o;
    endfunction

    function automatic out_t e_i_exec(input logic [2:0] op);
        out_t o = e_blank(4'd11);
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = op;
        return o;
    endfunction

    function automatic out_t e_i_wb();
        out_t o = e_blank(4'd12);
        o.reg_write = 1'b1;
        return o;
    endfunction

    function automatic out_t e_jal();
        out_t o = e_blank(4'd13);
        o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        o.pc_write = 1'b1; o.pc_source = 2'b10;
        return o;
    endfunction

    function automatic void push_exp(input out_t e, input string name);
        exp_t x;
        x.v    = e;
        x.name = name;
        sb_q.push_back(x);
    endfunction

    // One clock cycle: new inputs just after the edge, expectation queued
    task automatic apply_stimulus(input logic rst_v, input logic [5:0] op,
                                  input logic jr, input out_t e, input string name);
        @(posedge clk);
        #1;
        reset  = rst_v;
        Opcode = op;
        JR     = jr;
        push_exp(e, name);
    endtask

    task automatic check_output(input exp_t x);
        out_t act;
        act.state         = State;
        act.alu_op        = ALUOp;
        act.pc_write      = PCWrite;
        act.pc_write_cond = PCWriteCond;
        act.branch_ne     = BranchNE;
        act.i_or_d        = IorD;
        act.mem_read      = MemRead;
        act.mem_write     = MemWrite;
        act.ir_write      = IRWrite;
        act.mem_to_reg    = MemtoReg;
        act.reg_dst       = RegDst;
        act.reg_write     = RegWrite;
        act.alu_src_a     = ALUSrcA;
        act.alu_src_b     = ALUSrcB;
        act.pc_source     = PCSource;
        act.illegal_op    = IllegalOp;
        vectors++;
        if (act !== x.v) begin
            miscompares++;
            $display("[TB] FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                     x.name, act.state, act, x.v.state, x.v);
        end
    endtask

    // Monitor: samples mid-cycle, and also right after reset falls so the
    // asynchronous clear is observed before any clock edge
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check_output(x);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [5:0] i_ops [4];
    logic [2:0] i_alu [4];

    initial begin : stimulus
        i_ops = '{6'b001100, 6'b001101, 6'b001111, 6'b001000};
        i_alu = '{3'b110,    3'b101,    3'b011,    3'b100};

        reset  = 1'b0;
        Opcode = OP_LW;
        JR     = 1'b0;

        // Reset held low for three cycles
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, OP_LW, 1'b0, e_idle(), "reset_hold");
        apply_stimulus(1'b1, OP_LW, 1'b0, e_idle(), "release_idle");

        // LW: 1,2,3,4,5,1
        apply_stimulus(1'b1, OP_LW, 1'b0, e_fetch(),      "lw_fetch");
        apply_stimulus(1'b1, OP_LW, 1'b0, e_decode(1'b0), "lw_decode");
        apply_stimulus(1'b1, OP_LW, 1'b0, e_mem_addr(),   "lw_mem_addr");
        apply_stimulus(1'b1, OP_LW, 1'b0, e_mem_read(),   "lw_mem_read");
        apply_stimulus(1'b1, OP_LW, 1'b0, e_mem_wb(),     "lw_mem_wb");

        // R-type without JR
        apply_stimulus(1'b1, OP_R, 1'b0, e_fetch(),       "r_fetch");
        apply_stimulus(1'b1, OP_R, 1'b0, e_decode(1'b0),  "r_decode");
        apply_stimulus(1'b1, OP_R, 1'b0, e_r_exec(1'b0),  "r_exec");
        apply_stimulus(1'b1, OP_R, 1'b0, e_r_wb(),        "r_wb");

        // JR: flag high throughout, only R_EXEC may react to it
        apply_stimulus(1'b1, OP_R, 1'b1, e_fetch(),       "jr_fetch");
        apply_stimulus(1'b1, OP_R, 1'b1, e_decode(1'b0),  "jr_decode");
        apply_stimulus(1'b1, OP_R, 1'b1, e_r_exec(1'b1),  "jr_exec");

        // I-type ALUOp selection
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, i_ops[i], 1'b0, e_fetch(),          "i_fetch");
            apply_stimulus(1'b1, i_ops[i], 1'b0, e_decode(1'b0),     "i_decode");
            apply_stimulus(1'b1, i_ops[i], 1'b0, e_i_exec(i_alu[i]), "i_exec_aluop");
            apply_stimulus(1'b1, i_ops[i], 1'b0, e_i_wb(),           "i_wb");
        end

        // Branches and jump
        apply_stimulus(1'b1, OP_BNE, 1'b0, e_fetch(),       "bne_fetch");
        apply_stimulus(1'b1, OP_BNE, 1'b0, e_decode(1'b0),  "bne_decode");
        apply_stimulus(1'b1, OP_BNE, 1'b0, e_branch(1'b1),  "bne_branch");
        apply_stimulus(1'b1, OP_BEQ, 1'b0, e_fetch(),       "beq_fetch");
        apply_stimulus(1'b1, OP_BEQ, 1'b0, e_decode(1'b0),  "beq_decode");
        apply_stimulus(1'b1, OP_BEQ, 1'b0, e_branch(1'b0),  "beq_branch");
        apply_stimulus(1'b1, OP_J,   1'b0, e_fetch(),       "j_fetch");
        apply_stimulus(1'b1, OP_J,   1'b0, e_decode(1'b0),  "j_decode");
        apply_stimulus(1'b1, OP_J,   1'b0, e_jump(),        "j_jump");

        // Illegal opcode returns straight to FETCH
        apply_stimulus(1'b1, OP_BAD, 1'b0, e_fetch(),       "bad_fetch");
        apply_stimulus(1'b1, OP_BAD, 1'b0, e_decode(1'b1),  "bad_decode");

        // JAL: only legal with the link feature built in
        apply_stimulus(1'b1, OP_JAL, 1'b0, e_fetch(),       "jal_fetch");
`ifdef MIPS_CTRL_JAL_EN
        apply_stimulus(1'b1, OP_JAL, 1'b0, e_decode(1'b0),  "jal_decode");
        apply_stimulus(1'b1, OP_JAL, 1'b0, e_jal(),         "jal_link");
`else
        apply_stimulus(1'b1, OP_JAL, 1'b0, e_decode(1'b1),  "jal_illegal");
`endif

        // SW interrupted by an asynchronous reset in MEM_WRITE
        apply_stimulus(1'b1, OP_SW, 1'b0, e_fetch(),        "sw_fetch");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_decode(1'b0),   "sw_decode");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_mem_addr(),     "sw_mem_addr");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_mem_write(),    "sw_mem_write");
        @(negedge clk);
        #3;
        push_exp(e_idle(), "sw_async_reset");
        reset = 1'b0;
        apply_stimulus(1'b0, OP_SW, 1'b0, e_idle(),         "sw_reset_hold");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_idle(),         "sw_release_idle");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_fetch(),        "sw_re_fetch");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_decode(1'b0),   "sw_re_decode");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_mem_addr(),     "sw_re_mem_addr");
        apply_stimulus(1'b1, OP_SW, 1'b0, e_mem_write(),    "sw_re_mem_write");
        apply_stimulus(1'b1, OP_R,  1'b0, e_fetch(),        "final_fetch");

        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
